// File: rtl/data_mem_resp.sv
// data_mem_resp: multi-cycle data-memory responder. One request at a time;
// Stall holds the requester off for LATENCY cycles, then a one-cycle Done
// pulse completes the access. Misaligned, out-of-range or Rd&Wr requests are
// rejected with a one-cycle err pulse.
module data_mem_resp #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  // Request captured at accept time; inputs are ignored while BUSY.
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [15:0]   data;
    logic          wr;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        req;
  logic [15:0] mem [DEPTH];

  logic valid, legal, accept, illegal;

  // Exactly one of Rd/Wr makes a request; both at once is rejected.
  assign valid   = Rd ^ Wr;
  // Word aligned and no address bits above the array.
  assign legal   = ~Addr[0] & ((Addr >> (AW + 1)) == 16'd0);
  assign accept  = (state == IDLE) & valid & legal;
  assign illegal = (state == IDLE) & ((Rd & Wr) | (valid & ~legal));

  // Stall covers the accept cycle too, so the requester holds from cycle 0.
  assign Stall   = (state == BUSY) | accept;

  // Request FSM, latency counter, storage array and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req     <= '0;
      DataOut <= '0;
      Done    <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      Done <= 1'b0;
      err  <= illegal;
      if (state == IDLE) begin
        if (accept) begin
          req.idx  <= Addr[AW:1];
          req.data <= DataIn;
          req.wr   <= Wr;
          cnt      <= 4'(LATENCY - 1);
          state    <= BUSY;
        end
      end else begin
        if (cnt == 4'd1) begin
          // Write commits on the Done edge, so a read accepted in the Done
          // cycle sees the new value. DataOut only moves on reads.
          if (req.wr) mem[req.idx] <= req.data;
          else        DataOut      <= mem[req.idx];
          Done  <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one LATENCY=4 and one LATENCY=2 instance
// share the request inputs; sel picks which instance's outputs are checked.
module tb_data_mem_resp;
  logic        clk, rst;
  logic [15:0] Addr, DataIn;
  logic        Rd, Wr;
  logic [15:0] dout4, dout2;
  logic        done4, done2, stall4, stall2, err4, err2;
  logic        sel;
  int          checks, failures;

  data_mem_resp #(.DEPTH(64), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(dout4), .Done(done4), .Stall(stall4), .err(err4));

  data_mem_resp #(.DEPTH(64), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(dout2), .Done(done2), .Stall(stall2), .err(err2));

  wire [15:0] dout_s  = sel ? dout2  : dout4;
  wire        done_s  = sel ? done2  : done4;
  wire        stall_s = sel ? stall2 : stall4;
  wire        err_s   = sel ? err2   : err4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
  endtask

  // Present a request in the current cycle, wait (bounded) for Done and
  // return positioned inside the Done cycle with inputs idle.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int lat, input logic noise,
                        input string tag);
    int n;
    Rd = rd; Wr = wr; Addr = a; DataIn = d; #1;
    chk({tag, "_stall_c0"}, stall_s, 1);
    tick();
    if (noise) begin
      Rd = 1'b0; Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h1234;
    end else idle_in();
    #1;
    n = 1;
    while (done_s !== 1'b1 && n < 20) begin
      chk({tag, "_stall_busy"}, stall_s, 1);
      chk({tag, "_err_busy"}, err_s, 0);
      tick(); idle_in(); #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_stall_done"}, stall_s, 0);
  endtask

  // Illegal request from IDLE: no Stall, err next cycle only, no Done.
  task automatic bad_req(input logic rd, input logic wr, input logic [15:0] a,
                         input string tag);
    Rd = rd; Wr = wr; Addr = a; DataIn = 16'hFFFF; #1;
    chk({tag, "_stall"}, stall_s, 0);
    tick(); idle_in(); #1;
    chk({tag, "_err1"}, err_s, 1);
    chk({tag, "_done1"}, done_s, 0);
    tick(); #1;
    chk({tag, "_err0"}, err_s, 0);
    chk({tag, "_done0"}, done_s, 0);
  endtask

  logic [15:0] sb [8];
  logic [15:0] sa [8];

  initial begin
    checks = 0; failures = 0;
    sel = 1'b0; rst = 1'b0; idle_in();
    #12;
    chk("rst_done", done_s, 0);
    chk("rst_err", err_s, 0);
    chk("rst_dout", dout_s, 0);
    chk("rst_stall", stall_s, 0);
    tick();
    rst = 1'b1;

    // First request in the first cycle out of reset.
    access(1'b1, 1'b0, 16'h0000, 16'h0000, 4, 1'b0, "rd0");
    chk("rd0_dout", dout_s, 16'h0000);
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 4, 1'b0, "wr10");
    chk("wr10_dout_held", dout_s, 16'h0000);
    // Read issued in the write's Done cycle sees the new value.
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, "rd10");
    chk("rd10_dout", dout_s, 16'hBEEF);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 4, 1'b0, "rd20a");
    chk("rd20a_dout", dout_s, 16'h0000);
    // Inputs toggled during BUSY must be ignored.
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b1, "rd10n");
    chk("rd10n_dout", dout_s, 16'hBEEF);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 4, 1'b0, "rd20b");
    chk("rd20b_unchanged", dout_s, 16'h0000);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, "rd10b");
    chk("rd10b_dout", dout_s, 16'hBEEF);
    tick();

    bad_req(1'b1, 1'b0, 16'h0011, "misalign");
    bad_req(1'b1, 1'b0, 16'h0080, "range");
    bad_req(1'b1, 1'b1, 16'h0010, "rdwr");
    chk("bad_dout_held", dout_s, 16'hBEEF);

    // Reset during a pending write: outputs clear at once, write discarded.
    Rd = 1'b0; Wr = 1'b1; Addr = 16'h0004; DataIn = 16'h5555; #1;
    chk("rstw_stall_c0", stall_s, 1);
    tick(); idle_in();
    tick();
    rst = 1'b0; #1;
    chk("rstw_stall", stall_s, 0);
    chk("rstw_done", done_s, 0);
    chk("rstw_dout", dout_s, 16'h0000);
    tick();
    rst = 1'b1;
    access(1'b1, 1'b0, 16'h0004, 16'h0000, 4, 1'b0, "rd4");
    chk("rd4_dout", dout_s, 16'h0000);
    tick();

    // LATENCY=2 instance: back-to-back writes then reads.
    sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'(i * 6);
      sb[i] = 16'hA000 + 16'(i * 16'h0111);
    end
    for (int i = 0; i < 8; i++)
      access(1'b0, 1'b1, sa[i], sb[i], 2, 1'b0, "l2wr");
    for (int i = 0; i < 8; i++) begin
      access(1'b1, 1'b0, sa[i], 16'h0000, 2, 1'b0, "l2rd");
      chk("l2rd_dout", dout_s, sb[i]);
    end
    tick();
    chk("l2_done_pulse", done_s, 0);
    chk("l2_dout_hold", dout_s, sb[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Multi-cycle data-memory responder: the memory end of the Memory stage's request interface. It accepts one read or write request at a time, holds the requester off with `Stall` for a fixed programmable latency, then completes with a one-cycle `Done` pulse and read data. Replaces the single-cycle `memory2c` model so the pipeline's `stall_m` path is exercised with real back-pressure, with alignment and range errors flagged.

## Interface
- `DEPTH`, 64: number of 16-bit words; power of two, 2..1024.
- `LATENCY`, 4: cycles from request sample to `Done`; integer, 2..15.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset; clock and reset ports are `clk` and `rst`.
- `Addr`  in  16  byte address; bit 0 must be 0.
- `DataIn`  in  16  write data.
- `Rd`  in  1  read request.
- `Wr`  in  1  write request.
- `DataOut`  out  16  read data; valid while `Done`=1, then held.
- `Done`  out  1  one-cycle completion pulse, registered.
- `Stall`  out  1  requester must hold/stall; combinational.
- `err`  out  1  one-cycle rejected-request pulse, registered.

## Operation
- Storage: `DEPTH` x 16 array, word index `Addr[log2(DEPTH):1]`.
- Request valid = `Rd ^ Wr`; `Rd & Wr` is an illegal request.
- Request legal when `Addr[0]`=0 and `Addr[15:log2(DEPTH)+1]`=0.
- FSM states: IDLE, BUSY.
  - IDLE, valid legal request: latch Addr, DataIn, Wr; counter <= LATENCY-1; go BUSY.
  - IDLE, illegal request (misaligned, out of range, or Rd&Wr): `err`<=1 next cycle; stay IDLE; no access, no `Done`.
  - IDLE, no request: stay IDLE.
  - BUSY: counter decrements each cycle; `Rd`, `Wr`, `Addr`, `DataIn` ignored.
  - BUSY, counter==1: at the next edge perform the access (write commits array, or read loads `DataOut`), `Done`<=1, go IDLE.
- `Stall` = (state==BUSY) | (state==IDLE & valid legal request).
- Write completion: `DataOut` unchanged.
- `DataOut` holds the last read value until the next read completion.
- Write completion updates the array in the same edge `Done` rises; a read issued in the `Done` cycle sees the new value.

## Timing
- Reset (`rst`=0, async): state IDLE, counter 0, `DataOut`=0, `Done`=0, `err`=0, all array words = 0; `Stall` evaluates to 0 with no request. In-flight request aborted, pending write discarded.
- Request sampled at edge E0 in cycle 0; `Stall`=1 cycles 0..LATENCY-1; `Done`=1 in cycle LATENCY only; `Stall`=0 in cycle LATENCY unless a new request is presented.
- Back-to-back: new request presented in the `Done` cycle is accepted at once; throughput one access per LATENCY cycles.
- `err` high exactly in the cycle after the illegal request; `Stall` stays 0 for illegal requests.
- `Done` and `err` never both high.
- Reset deassertion: first request may be presented in the first cycle with `rst`=1.

## Test plan
- Reset, then `Rd` Addr=0x0000, LATENCY=4 -> `Stall`=1 cycles 0-3, `Done`=1 cycle 4, `DataOut`=0x0000.
- `Wr` Addr=0x0010 DataIn=0xBEEF, then `Rd` Addr=0x0010 in `Done` cycle -> second `Done` 4 cycles later, `DataOut`=0xBEEF; `Stall` continuous except none dropped.
- `Rd` Addr=0x0011 -> `err`=1 for one cycle next cycle, `Stall`=0, no `Done`; same for Addr=0x0080 (DEPTH=64) and `Rd`=`Wr`=1.
- During BUSY of `Rd` 0x0010, toggle `Addr`=0x0020 and `Wr`=1 DataIn=0x1234 -> ignored; `DataOut`=0xBEEF, word 0x0020 unchanged.
- `Wr` 0x0004=0x5555, assert `rst`=0 at cycle 2 -> outputs 0 immediately; after release, `Rd` 0x0004 returns 0x0000.
- LATENCY=2: `Rd` every `Done` cycle for 8 addresses -> `Done` every 2 cycles, data matches scoreboard.
